tour_cmd_sequencer: RTL and testbench
=====================================

// Module: tour_cmd_sequencer
// PURPOSE
//  Sequences the solved knight's tour into motion commands for the command processor.
//  Muxes two command sources: UART (idle) and the tour (after start_tour).
//  Reads the tour solver's one-hot move table via mv_indx and turns each move into two commands:
//  a vertical leg, then a horizontal leg with fanfare.
//  Selects the response byte returned to the host.
// PARAMETERS
//  NUM_MOVES  24  moves in a 5x5 tour; the sequencer issues 2*NUM_MOVES commands
//  IDX_W      5   width of mv_indx; must satisfy 2**IDX_W >= NUM_MOVES
// PORTS
//  clk            in   1      system clock, posedge
//  rst_n          in   1      async active-low reset
//  start_tour     in   1      1-clk pulse from the solver's done; starts a tour
//  move           in   8      one-hot move at mv_indx, valid combinationally
//  mv_indx        out  IDX_W  index into the solver's move table
//  cmd_UART       in   16     command from UART wrapper
//  cmd_rdy_UART   in   1      UART command valid
//  clr_cmd_rdy_UART out 1     consume UART command
//  cmd            out  16     command to cmd processor: [15:12] opcode, [11:4] heading, [3:0] squares
//  cmd_rdy        out  1      cmd valid
//  clr_cmd_rdy    in   1      cmd processor consumed cmd
//  send_resp      in   1      cmd processor finished the current command
//  resp           out  8      response byte: 8'hA5 = ack/final, 8'h5A = tour in progress
// BEHAVIOUR
//  Reset:
//   - State returns to IDLE and mv_indx to 0.
//   - Outputs: cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, clr_cmd_rdy_UART = 0, resp = 8'hA5.
//  Move encoding, bit -> (dx,dy):
//   b0(+1,+2) b1(-1,+2) b2(-2,+1) b3(-2,-1) b4(-1,-2) b5(+1,-2) b6(+2,-1) b7(+2,+1).
//   - A non-one-hot move uses its lowest set bit.
//   - A zero move gives dx = dy = 0; both legs are still issued with squares = 0.
//  Commands:
//   - Vertical leg: opcode 4'b0010, heading 8'h00 (N, dy>0) or 8'h7F (S), squares = |dy|.
//   - Horizontal leg: opcode 4'b0011, heading 8'hBF (E, dx>0) or 8'h3F (W), squares = |dx|.
//  FSM, states IDLE, VERT, WAIT_V, HORZ, WAIT_H:
//   - IDLE: UART passthrough. cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, clr_cmd_rdy_UART = clr_cmd_rdy.
//     start_tour moves to VERT and clears mv_indx.
//   - VERT: cmd = vertical leg, cmd_rdy = 1 (combinational). clr_cmd_rdy moves to WAIT_V.
//   - WAIT_V: cmd_rdy = 0. send_resp moves to HORZ.
//   - HORZ: cmd = horizontal leg, cmd_rdy = 1. clr_cmd_rdy moves to WAIT_H.
//   - WAIT_H: cmd_rdy = 0. On send_resp:
//     - if mv_indx == NUM_MOVES-1, go to IDLE and clear mv_indx;
//     - else increment mv_indx and go to VERT.
//  Tour timing:
//   - First tour cmd_rdy is asserted the cycle after start_tour.
//   - mv_indx is stable through all four states of one move.
//   - The next move's cmd is valid the cycle after the final send_resp of the previous move.
//  resp (combinational):
//   - 8'hA5 in IDLE.
//   - 8'hA5 in WAIT_H when mv_indx == NUM_MOVES-1.
//   - 8'h5A otherwise.
//  Boundaries:
//   - start_tour outside IDLE is ignored.
//   - cmd_rdy_UART/cmd_UART are ignored during a tour; clr_cmd_rdy_UART = 0 outside IDLE.
//   - clr_cmd_rdy and send_resp in the same cycle in VERT/HORZ: clr wins; send_resp is dropped.
//   - send_resp in VERT/HORZ without clr is ignored.
//   - Reset mid-tour aborts to IDLE with mv_indx = 0; there is no resume.
// STRUCTURE
//  Package jk_cmd_pkg:
//   - opcode constants MOVE = 4'b0010, MOVE_FANFARE = 4'b0011
//   - heading constants HEAD_N/HEAD_W/HEAD_S/HEAD_E
//   - response constants RESP_ACK = 8'hA5, RESP_BUSY = 8'h5A
//   - state enum tour_state_t
//  Sub-module tour_move_decode (combinational): move[7:0] -> vert cmd[15:0], horz cmd[15:0].
//  Top level holds the FSM, mv_indx counter and output muxes.
// TESTING
//  1 Idle passthrough:
//    cmd_UART = 16'h2_00_3, cmd_rdy_UART = 1 -> cmd = 16'h2003, cmd_rdy = 1.
//    clr_cmd_rdy pulse -> clr_cmd_rdy_UART pulse, same cycle. resp = 8'hA5.
//  2 Single move b0:
//    start_tour -> next clk cmd = 16'h2_00_2, cmd_rdy = 1.
//    clr + send_resp -> cmd = 16'h3_BF_1, resp = 8'h5A.
//    send_resp -> mv_indx = 1.
//  3 Full tour:
//    model returns move = 8'h01 << (i%8) -> exactly 48 cmd_rdy assertions with the expected decoded cmds.
//    Final send_resp with resp = 8'hA5 -> IDLE, mv_indx = 0.
//  4 Ignored inputs:
//    start_tour and cmd_rdy_UART pulsed mid-tour -> no state, indx or cmd change; clr_cmd_rdy_UART stays 0.
//  5 Reset mid-tour:
//    rst_n low at mv_indx = 7, WAIT_V -> IDLE, mv_indx = 0, cmd_rdy follows cmd_rdy_UART.
//  6 Odd moves:
//    move = 8'h00 -> cmds 16'h2000 / 16'h3BF0 (dx = dy = 0 -> positive headings N/E).
//    move = 8'h84 -> decoded as b2 -> 16'h2_00_1, 16'h3_3F_2.

Source files
------------

// File: rtl/jk_cmd_pkg.sv
// Shared constants and state type for the knight's-tour command sequencer.
// Commands are {opcode[3:0], heading[7:0], squares[3:0]}.
package jk_cmd_pkg;

  localparam logic [3:0] MOVE         = 4'b0010;
  localparam logic [3:0] MOVE_FANFARE = 4'b0011;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } tour_state_t;

endpackage

// File: rtl/tour_move_decode.sv
// Turns one knight move (one-hot, lowest set bit wins) into its vertical
// and horizontal leg commands. A zero move yields zero-square legs heading N/E.
module tour_move_decode
  import jk_cmd_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  always_comb begin
    vert_cmd = {MOVE, HEAD_N, 4'd0};
    horz_cmd = {MOVE_FANFARE, HEAD_E, 4'd0};
    casez (move)
      8'b???????1: begin  // (+1,+2)
        vert_cmd = {MOVE, HEAD_N, 4'd2};
        horz_cmd = {MOVE_FANFARE, HEAD_E, 4'd1};
      end
      8'b??????10: begin  // (-1,+2)
        vert_cmd = {MOVE, HEAD_N, 4'd2};
        horz_cmd = {MOVE_FANFARE, HEAD_W, 4'd1};
      end
      8'b?????100: begin  // (-2,+1)
        vert_cmd = {MOVE, HEAD_N, 4'd1};
        horz_cmd = {MOVE_FANFARE, HEAD_W, 4'd2};
      end
      8'b????1000: begin  // (-2,-1)
        vert_cmd = {MOVE, HEAD_S, 4'd1};
        horz_cmd = {MOVE_FANFARE, HEAD_W, 4'd2};
      end
      8'b???10000: begin  // (-1,-2)
        vert_cmd = {MOVE, HEAD_S, 4'd2};
        horz_cmd = {MOVE_FANFARE, HEAD_W, 4'd1};
      end
      8'b??100000: begin  // (+1,-2)
        vert_cmd = {MOVE, HEAD_S, 4'd2};
        horz_cmd = {MOVE_FANFARE, HEAD_E, 4'd1};
      end
      8'b?1000000: begin  // (+2,-1)
        vert_cmd = {MOVE, HEAD_S, 4'd1};
        horz_cmd = {MOVE_FANFARE, HEAD_E, 4'd2};
      end
      8'b10000000: begin  // (+2,+1)
        vert_cmd = {MOVE, HEAD_N, 4'd1};
        horz_cmd = {MOVE_FANFARE, HEAD_E, 4'd2};
      end
      default: begin
        vert_cmd = {MOVE, HEAD_N, 4'd0};
        horz_cmd = {MOVE_FANFARE, HEAD_E, 4'd0};
      end
    endcase
  end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Muxes UART commands and the solved tour into the command processor,
// issuing a vertical then a horizontal leg for every move in the table.
module tour_cmd_sequencer
  import jk_cmd_pkg::*;
#(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic [2:0]       dbg_state
);

  // Handshake: cmd is valid while cmd_rdy is high; the command processor
  // takes it by pulsing clr_cmd_rdy and later reports completion with send_resp.

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  tour_state_t      state_q, state_d;
  logic [IDX_W-1:0] indx_q, indx_d;
  logic [15:0]      vert_cmd, horz_cmd;
  logic             last_move;

  tour_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd)
  );

  assign last_move = (indx_q == LAST_IDX);
  assign mv_indx   = indx_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      indx_q  <= '0;
    end else begin
      state_q <= state_d;
      indx_q  <= indx_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    indx_d           = indx_q;
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_BUSY;
    case (state_q)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_ACK;
        if (start_tour) begin
          state_d = VERT;
          indx_d  = '0;
        end
      end
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = WAIT_V;
      end
      WAIT_V: begin
        cmd = vert_cmd;
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = WAIT_H;
      end
      WAIT_H: begin
        cmd = horz_cmd;
        // The ack on the final leg tells the host the whole tour is done.
        if (last_move) resp = RESP_ACK;
        if (send_resp) begin
          if (last_move) begin
            state_d = IDLE;
            indx_d  = '0;
          end else begin
            state_d = VERT;
            indx_d  = indx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        indx_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed + randomized bench for tour_cmd_sequencer: UART passthrough,
// full tours against a displacement-table model, ignored inputs and reset abort.
module tb_tour_cmd_sequencer;
  import jk_cmd_pkg::*;

  localparam int NUM_MOVES = 24;
  localparam int IDX_W     = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_tour;
  logic [7:0]       move;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd_UART;
  logic             cmd_rdy_UART;
  logic             clr_cmd_rdy_UART;
  logic [15:0]      cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic             send_resp;
  logic [7:0]       resp;
  logic [2:0]       dbg_state;

  logic [7:0]  move_tbl [32];
  logic [15:0] exp_q [$];
  int          tests = 0;
  int          fails = 0;
  int          rises = 0;
  logic        prev_rdy = 1'b0;

  assign move = move_tbl[mv_indx];

  tour_cmd_sequencer #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_rdy && !prev_rdy) rises++;
    prev_rdy = cmd_rdy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: knight displacement table, lowest set bit wins
  function automatic logic [15:0] model_leg(input logic [7:0] mv, input bit horiz);
    int dx_t [8];
    int dy_t [8];
    int dx, dy;
    bit found;
    dx_t = '{1, -1, -2, -2, -1, 1, 2, 2};
    dy_t = '{2, 2, 1, -1, -2, -2, -1, 1};
    dx = 0; dy = 0; found = 0;
    for (int b = 0; b < 8; b++) begin
      if (mv[b] && !found) begin
        dx = dx_t[b];
        dy = dy_t[b];
        found = 1;
      end
    end
    if (horiz)
      return {4'b0011, (dx >= 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
    else
      return {4'b0010, (dy >= 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
  endfunction

  // driver: one move's four-state handshake; returns early when aborting
  task automatic do_move(input int i, input int inject_at, input int abort_at);
    check("vert_rdy", 32'(cmd_rdy), 32'd1);
    check("vert_cmd", 32'(cmd), 32'(exp_q.pop_front()));
    check("vert_indx", 32'(mv_indx), 32'(i));
    check("vert_resp", 32'(resp), 32'h5A);
    if ($urandom_range(0, 2) == 0) begin
      send_resp = 1'b1;
      @(negedge clk) send_resp = 1'b0;
      check("vert_ign_send", 32'(dbg_state), 32'(VERT));
    end
    clr_cmd_rdy = 1'b1;
    send_resp = 1'($urandom_range(0, 1));
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    #1;
    check("waitv_state", 32'(dbg_state), 32'(WAIT_V));
    check("waitv_rdy", 32'(cmd_rdy), 32'd0);
    if (i == inject_at) begin
      start_tour = 1'b1;
      cmd_rdy_UART = 1'b1;
      cmd_UART = 16'($urandom);
      clr_cmd_rdy = 1'b1;
      #1;
      check("inj_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
      check("inj_rdy", 32'(cmd_rdy), 32'd0);
      @(negedge clk);
      start_tour = 1'b0;
      cmd_rdy_UART = 1'b0;
      clr_cmd_rdy = 1'b0;
      #1;
      check("inj_state", 32'(dbg_state), 32'(WAIT_V));
      check("inj_indx", 32'(mv_indx), 32'(i));
    end
    if (i == abort_at) return;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check("waitv_resp", 32'(resp), 32'h5A);
    send_resp = 1'b1;
    @(negedge clk) send_resp = 1'b0;
    #1;
    check("horz_rdy", 32'(cmd_rdy), 32'd1);
    check("horz_cmd", 32'(cmd), 32'(exp_q.pop_front()));
    check("horz_indx", 32'(mv_indx), 32'(i));
    check("horz_resp", 32'(resp), 32'h5A);
    clr_cmd_rdy = 1'b1;
    send_resp = 1'($urandom_range(0, 1));
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    #1;
    check("waith_state", 32'(dbg_state), 32'(WAIT_H));
    check("waith_rdy", 32'(cmd_rdy), 32'd0);
    check("waith_indx", 32'(mv_indx), 32'(i));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check("waith_resp", 32'(resp), (i == NUM_MOVES - 1) ? 32'hA5 : 32'h5A);
    send_resp = 1'b1;
    @(negedge clk) send_resp = 1'b0;
    #1;
  endtask

  task automatic run_tour(input int inject_at, input int abort_at);
    exp_q.delete();
    for (int m = 0; m < NUM_MOVES; m++) begin
      exp_q.push_back(model_leg(move_tbl[m], 1'b0));
      exp_q.push_back(model_leg(move_tbl[m], 1'b1));
    end
    rises = 0;
    start_tour = 1'b1;
    @(negedge clk) start_tour = 1'b0;
    #1;
    check("start_state", 32'(dbg_state), 32'(VERT));
    for (int m = 0; m < NUM_MOVES; m++) begin
      do_move(m, inject_at, abort_at);
      if (m == abort_at) break;
    end
    if (abort_at >= 0) begin
      rst_n = 1'b0;
      #1;
      check("abort_state", 32'(dbg_state), 32'(IDLE));
      check("abort_indx", 32'(mv_indx), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      cmd_rdy_UART = 1'b1;
      cmd_UART = 16'($urandom);
      #1;
      check("abort_rdy", 32'(cmd_rdy), 32'd1);
      check("abort_cmd", 32'(cmd), 32'(cmd_UART));
      @(negedge clk) cmd_rdy_UART = 1'b0;
      exp_q.delete();
    end else begin
      check("end_state", 32'(dbg_state), 32'(IDLE));
      check("end_indx", 32'(mv_indx), 32'd0);
      check("end_resp", 32'(resp), 32'hA5);
      check("rdy_count", 32'(rises), 32'd48);
      check("exp_empty", 32'(exp_q.size()), 32'd0);
    end
  endtask

  function automatic logic [7:0] rand_move();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return 8'h01 << $urandom_range(0, 7);
  endfunction

  initial begin
    rst_n = 1'b0;
    start_tour = 1'b0;
    cmd_UART = 16'hBEEF;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    for (int m = 0; m < 32; m++) move_tbl[m] = 8'h00;
    #1;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_indx", 32'(mv_indx), 32'd0);
    check("rst_cmd", 32'(cmd), 32'hBEEF);
    check("rst_rdy", 32'(cmd_rdy), 32'd1);
    check("rst_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
    check("rst_resp", 32'(resp), 32'hA5);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmd_rdy_UART = 1'b0;

    // idle passthrough
    cmd_UART = 16'h2003;
    cmd_rdy_UART = 1'b1;
    #1;
    check("idle_cmd", 32'(cmd), 32'h2003);
    check("idle_rdy", 32'(cmd_rdy), 32'd1);
    check("idle_resp", 32'(resp), 32'hA5);
    check("idle_clr0", 32'(clr_cmd_rdy_UART), 32'd0);
    clr_cmd_rdy = 1'b1;
    #1;
    check("idle_clr1", 32'(clr_cmd_rdy_UART), 32'd1);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cmd_UART = 16'($urandom);
      cmd_rdy_UART = 1'($urandom_range(0, 1));
      #1;
      check("idle_rand_cmd", 32'(cmd), 32'(cmd_UART));
      check("idle_rand_rdy", 32'(cmd_rdy), 32'(cmd_rdy_UART));
      @(negedge clk);
    end
    cmd_rdy_UART = 1'b0;
    @(negedge clk);

    // full tour, shifting one-hot pattern
    for (int m = 0; m < NUM_MOVES; m++) move_tbl[m] = 8'h01 << (m % 8);
    run_tour(-1, -1);

    // random tour with odd moves and ignored inputs mid-tour
    for (int m = 0; m < NUM_MOVES; m++) move_tbl[m] = rand_move();
    move_tbl[0] = 8'h00;
    move_tbl[1] = 8'h84;
    run_tour(5, -1);

    // reset mid-tour at move 7, WAIT_V
    for (int m = 0; m < NUM_MOVES; m++) move_tbl[m] = rand_move();
    run_tour(-1, 7);

    // another random tour after the abort
    for (int m = 0; m < NUM_MOVES; m++) move_tbl[m] = rand_move();
    run_tour(12, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
